mem_store_buffer: RTL and testbench

//  Posted-write buffer in the MEM stage, between the EX/MEM pipeline register and the word-addressed data memory.

---
 rtl/mem_store_buffer.sv | 100 ++++++++++
 tb/tb_mem_store_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer for the MEM stage: queues stores, drains them when the
// memory port is free, and forwards buffered data to loads with zero latency.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] mr,
    input  logic [31:0]   mqb,
    input  logic          mwmem,
    input  logic          mm2reg,
    input  logic          msync,
    input  logic [31:0]   dm_do,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_data,
    output logic          dm_we,
    output logic [31:0]   mdo,
    output logic          stall,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-3:0] entry_addr [DEPTH];
    logic [31:0]   entry_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          full;
    logic          push;
    logic          pop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] idx;
    logic          unused_byte_bits;

    assign unused_byte_bits = ^mr[1:0];

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Store cycles keep the port idle unless full or a barrier is pending.
    assign pop   = ~mm2reg & ~empty & (~mwmem | full | msync);
    assign push  = mwmem & ~full;
    assign stall = (msync & ~empty) | (mwmem & full);

    always_comb begin
        dm_addr = mr;
        dm_data = mqb;
        dm_we   = 1'b0;
        if (pop) begin
            dm_addr = {entry_addr[head], 2'b00};
            dm_data = entry_data[head];
            dm_we   = 1'b1;
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (entry_addr[idx] == mr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end

    assign mdo = (mm2reg && fwd_hit) ? fwd_data : dm_do;

    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail] <= mr[AW-1:2];
            entry_data[tail] <= mqb;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a behavioural negedge-write data memory.
module tb_mem_store_buffer;

    logic        clk;
    logic        clrn;
    logic [31:0] mr;
    logic [31:0] mqb;
    logic        mwmem;
    logic        mm2reg;
    logic        msync;
    logic [31:0] dm_do;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic        dm_we;
    logic [31:0] mdo;
    logic        stall;
    logic        empty;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        mem_load;

    int n_cmp;
    int n_bad;

    mem_store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .clrn(clrn), .mr(mr), .mqb(mqb), .mwmem(mwmem),
        .mm2reg(mm2reg), .msync(msync), .dm_do(dm_do), .dm_addr(dm_addr),
        .dm_data(dm_data), .dm_we(dm_we), .mdo(mdo), .stall(stall), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign dm_do = mem[dm_addr[9:2]];

    always @(negedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (dm_we) begin
            mem[dm_addr[9:2]] <= dm_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic r, input logic s);
        mr = a; mqb = d; mwmem = w; mm2reg = r; msync = s;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        set_in(a, d, 1'b1, 1'b0, 1'b0);
        #2;
        while (stall === 1'b1 && n < 4) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("store_stall_bound", {31'd0, stall}, 32'd0);
        ref_mem[a[9:2]] = d;
        nxt();
    endtask

    task automatic do_load(input string tag, input logic [31:0] a);
        set_in(a, 32'd0, 1'b0, 1'b1, 1'b0);
        #2;
        chk(tag, mdo, ref_mem[a[9:2]]);
        chk({tag, "_we"}, {31'd0, dm_we}, 32'd0);
        nxt();
    endtask

    task automatic do_idle();
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        nxt();
    endtask

    task automatic idle_drain(input string tag, input logic [31:0] a, input logic [31:0] d);
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk({tag, "_we"}, {31'd0, dm_we}, 32'd1);
        chk({tag, "_addr"}, dm_addr, a);
        chk({tag, "_data"}, dm_data, d);
        nxt();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        clrn = 1'b0;
        mem_load = 1'b1;
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_we", {31'd0, dm_we}, 32'd0);
        chk("rst_mdo", mdo, 32'hC0DE_0000);
        nxt();
        mem_load = 1'b0;
        clrn = 1'b1;
        nxt();

        // Reset while draining: three buffered stores must be discarded.
        set_in(32'h50, 32'hA1, 1'b1, 1'b0, 1'b0); #2;
        chk("t1_store_no_we", {31'd0, dm_we}, 32'd0);
        nxt();
        set_in(32'h54, 32'hA2, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h58, 32'hA3, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("t1_drain_we", {31'd0, dm_we}, 32'd1);
        chk("t1_drain_addr", dm_addr, 32'h50);
        clrn = 1'b0;
        #1;
        chk("t1_async_empty", {31'd0, empty}, 32'd1);
        chk("t1_async_we", {31'd0, dm_we}, 32'd0);
        chk("t1_async_stall", {31'd0, stall}, 32'd0);
        nxt();
        clrn = 1'b1;
        nxt();
        chk("t1_mem_50", mem[8'h14], 32'hC0DE_0014);
        chk("t1_mem_54", mem[8'h15], 32'hC0DE_0015);
        do_load("t1_load_50", 32'h50);

        // Fill to DEPTH, then one store against a full buffer.
        set_in(32'h50, 32'hA3, 1'b1, 1'b0, 1'b0); #2;
        chk("t2_s0_we", {31'd0, dm_we}, 32'd0);
        nxt();
        set_in(32'h54, 32'h27, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h58, 32'h79, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h5C, 32'h115, 1'b1, 1'b0, 1'b0); #2;
        chk("t2_s3_we", {31'd0, dm_we}, 32'd0);
        chk("t2_s3_stall", {31'd0, stall}, 32'd0);
        nxt();
        set_in(32'h60, 32'h1, 1'b1, 1'b0, 1'b0); #2;
        chk("t2_full_stall", {31'd0, stall}, 32'd1);
        chk("t2_full_we", {31'd0, dm_we}, 32'd1);
        chk("t2_full_addr", dm_addr, 32'h50);
        chk("t2_full_data", dm_data, 32'hA3);
        nxt();
        #2;
        chk("t2_accept_stall", {31'd0, stall}, 32'd0);
        chk("t2_accept_we", {31'd0, dm_we}, 32'd0);
        nxt();
        idle_drain("t2_d1", 32'h54, 32'h27);
        idle_drain("t2_d2", 32'h58, 32'h79);
        idle_drain("t2_d3", 32'h5C, 32'h115);
        idle_drain("t2_d4", 32'h60, 32'h1);
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b0); #2;
        chk("t2_empty", {31'd0, empty}, 32'd1);
        chk("t2_empty_we", {31'd0, dm_we}, 32'd0);
        nxt();
        chk("t2_mem_50", mem[8'h14], 32'hA3);
        chk("t2_mem_60", mem[8'h18], 32'h1);

        // Forwarding from the youngest of two matching entries.
        set_in(32'h54, 32'h11, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h54, 32'h22, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h54, 32'd0, 1'b0, 1'b1, 1'b0); #2;
        chk("t3_fwd_mdo", mdo, 32'h22);
        chk("t3_fwd_we", {31'd0, dm_we}, 32'd0);
        nxt();
        set_in(32'h64, 32'd0, 1'b0, 1'b1, 1'b0); #2;
        chk("t3_miss_mdo", mdo, 32'hC0DE_0019);
        chk("t3_miss_addr", dm_addr, 32'h64);
        nxt();
        idle_drain("t3_d1", 32'h54, 32'h11);
        idle_drain("t3_d2", 32'h54, 32'h22);
        set_in(32'h54, 32'd0, 1'b0, 1'b1, 1'b0); #2;
        chk("t3_empty", {31'd0, empty}, 32'd1);
        chk("t3_mem_mdo", mdo, 32'h22);
        nxt();

        // Drain order on idle cycles.
        set_in(32'h70, 32'h7A, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h74, 32'h7B, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h78, 32'h7C, 1'b1, 1'b0, 1'b0); nxt();
        idle_drain("t4_d1", 32'h70, 32'h7A);
        idle_drain("t4_d2", 32'h74, 32'h7B);
        idle_drain("t4_d3", 32'h78, 32'h7C);
        set_in(32'h74, 32'd0, 1'b0, 1'b1, 1'b0); #2;
        chk("t4_empty", {31'd0, empty}, 32'd1);
        chk("t4_read_74", mdo, 32'h7B);
        nxt();
        chk("t4_mem_70", mem[8'h1C], 32'h7A);
        chk("t4_mem_78", mem[8'h1E], 32'h7C);

        // Sync barrier with two buffered stores, then with an empty buffer.
        set_in(32'h80, 32'h81, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'h84, 32'h82, 1'b1, 1'b0, 1'b0); nxt();
        set_in(32'd0, 32'd0, 1'b0, 1'b0, 1'b1); #2;
        chk("t5_c1_stall", {31'd0, stall}, 32'd1);
        chk("t5_c1_addr", dm_addr, 32'h80);
        chk("t5_c1_we", {31'd0, dm_we}, 32'd1);
        nxt();
        #2;
        chk("t5_c2_stall", {31'd0, stall}, 32'd1);
        chk("t5_c2_addr", dm_addr, 32'h84);
        chk("t5_c2_data", dm_data, 32'h82);
        nxt();
        #2;
        chk("t5_c3_stall", {31'd0, stall}, 32'd0);
        chk("t5_c3_empty", {31'd0, empty}, 32'd1);
        chk("t5_c3_we", {31'd0, dm_we}, 32'd0);
        nxt();
        #2;
        chk("t5_sync_empty_stall", {31'd0, stall}, 32'd0);
        nxt();

        // Interleaved stores, loads and idles; pointers wrap twice.
        do_store(32'hA0, 32'd1);
        do_store(32'hA4, 32'd2);
        do_load("t6_l_a0", 32'hA0);
        do_store(32'hA8, 32'd3);
        do_store(32'hAC, 32'd4);
        do_load("t6_l_a4", 32'hA4);
        do_idle();
        do_idle();
        do_store(32'hA0, 32'd5);
        do_store(32'hB0, 32'd6);
        do_load("t6_l_a0b", 32'hA0);
        do_idle();
        do_idle();
        do_store(32'hA4, 32'd7);
        do_load("t6_l_a8", 32'hA8);
        do_store(32'hB4, 32'd8);
        do_store(32'hA0, 32'd9);
        do_load("t6_l_a0c", 32'hA0);
        do_store(32'hB8, 32'd10);
        do_load("t6_l_b8", 32'hB8);
        repeat (6) do_idle();
        #2;
        chk("t6_empty", {31'd0, empty}, 32'd1);
        for (int i = 8'h28; i < 8'h30; i++) chk("t6_mem_image", mem[i], ref_mem[i]);
        do_load("t6_l_b4", 32'hB4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
